// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver.
// Synchronises the raw PS/2 clock/data pins, deserialises 11-bit frames
// (start, D0..D7 LSB first, odd parity, stop) and emits each good byte as a
// one-cycle strobe. Framing errors and inter-edge timeouts pulse o_err.
// Optional feature: define PS2_PARITY_CHECK_EN to reject frames with bad parity;
// without it the parity bit is clocked past and ignored.
module ps2_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       i_sclr,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_en,
  output logic       o_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic            clk_s1, clk_s2, clk_hist;
  logic            dat_s1, dat_s2;
  logic            fall;
  logic            parity_ok;
  state_e          state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic [CntW-1:0] tmo_cnt;

  // Two-flop synchronisers plus edge history; all reset high so reset never fakes a fall.
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_hist <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= i_ps2_clk;
      clk_s2   <= clk_s1;
      clk_hist <= clk_s2;
      dat_s1   <= i_ps2_data;
      dat_s2   <= dat_s1;
    end
  end

  assign fall = clk_hist & ~clk_s2;

`ifdef PS2_PARITY_CHECK_EN
  logic parity_bit;

  // Latch the received parity bit when the PARITY-state edge arrives.
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      parity_bit <= 1'b0;
    end else if (fall && state == StParity) begin
      parity_bit <= dat_s2;
    end
  end

  // Odd parity: data bits plus parity bit must XOR to one.
  assign parity_ok = ^{shift, parity_bit};
`else
  assign parity_ok = 1'b1;
`endif

  // Frame FSM, timeout counter and registered output strobes.
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      state     <= StIdle;
      bit_cnt   <= 3'd0;
      shift     <= 8'h00;
      tmo_cnt   <= '0;
      o_byte    <= 8'h00;
      o_byte_en <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      o_byte_en <= 1'b0;
      o_err     <= 1'b0;
      if (fall) begin
        // An edge always wins over a coincident timeout.
        tmo_cnt <= '0;
        case (state)
          StIdle: begin
            if (!dat_s2) begin
              state   <= StData;
              bit_cnt <= 3'd0;
            end
          end
          StData: begin
            shift[bit_cnt] <= dat_s2;
            bit_cnt        <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= StParity;
            end
          end
          StParity: begin
            state <= StStop;
          end
          StStop: begin
            if (dat_s2 && parity_ok) begin
              o_byte    <= shift;
              o_byte_en <= 1'b1;
            end else begin
              o_err <= 1'b1;
            end
            state <= StIdle;
          end
          default: state <= StIdle;
        endcase
      end else if (state == StIdle) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt >= CntLast) begin
        // Counter reaches TIMEOUT_CYCLES here; abort and drop the partial frame.
        o_err   <= 1'b1;
        state   <= StIdle;
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + CntW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: directed scenarios plus randomized frames
// checked against a frame-level reference model.
module tb_ps2_rx;

  localparam int unsigned TMO  = 64;
  localparam int          HALF = 8;  // clk cycles per PS/2 clock half-period

  logic       clk = 1'b0;
  logic       sclr = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] byte_o;
  logic       byte_en;
  logic       err;

  int         n_tests = 0;
  int         n_fail = 0;
  logic [8:0] ev_q[$];        // {is_err, byte}
  bit         both_seen = 1'b0;
  logic [7:0] last_good = 8'h00;

  ps2_rx #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .i_sclr    (sclr),
    .i_ps2_clk (ps2_clk),
    .i_ps2_data(ps2_data),
    .o_byte    (byte_o),
    .o_byte_en (byte_en),
    .o_err     (err)
  );

  always #5 clk = ~clk;

  // Record every strobe cycle; a stretched pulse shows up as an extra event.
  always @(negedge clk) begin
    if (byte_en && err) both_seen <= 1'b1;
    if (byte_en) ev_q.push_back({1'b0, byte_o});
    if (err) ev_q.push_back(9'h100);
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_clk(HALF / 2);
    ps2_clk = 1'b0;
    wait_clk(HALF);
    ps2_clk = 1'b1;
    wait_clk(HALF / 2);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b) ^ bad_par);
    send_bit(~bad_stop);
  endtask

  // Frame-level reference: what one frame should produce.
  function automatic logic [8:0] model(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    if (bad_stop) return 9'h100;
`ifdef PS2_PARITY_CHECK_EN
    if (bad_par) return 9'h100;
`endif
    return {1'b0, b};
  endfunction

  task automatic get_ev(output bit got, output logic [8:0] ev);
    for (int i = 0; i < 40 && ev_q.size() == 0; i++) wait_clk(1);
    got = (ev_q.size() != 0);
    ev  = got ? ev_q.pop_front() : 9'h1ff;
  endtask

  task automatic test_reset;
    sclr = 1'b1;
    wait_clk(4);
    n_tests++;
    if (byte_o !== 8'h00) begin n_fail++; $display("FAIL reset_byte got=%h exp=00", byte_o); end
    n_tests++;
    if (byte_en !== 1'b0) begin n_fail++; $display("FAIL reset_byte_en got=%b exp=0", byte_en); end
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
    sclr = 1'b0;
    wait_clk(8);
    n_tests++;
    if (ev_q.size() != 0) begin n_fail++; $display("FAIL reset_idle got=%0d events exp=0", ev_q.size()); end
    ev_q.delete();
  endtask

  task automatic test_valid_frame;
    bit got; logic [8:0] ev;
    send_frame(8'h1C, 1'b0, 1'b0);
    get_ev(got, ev);
    n_tests++;
    if (!got || ev !== 9'h01C) begin n_fail++; $display("FAIL valid_event got=%h exp=01c", ev); end
    n_tests++;
    if (byte_o !== 8'h1C) begin n_fail++; $display("FAIL valid_byte got=%h exp=1c", byte_o); end
    wait_clk(4);
    n_tests++;
    if (ev_q.size() != 0) begin n_fail++; $display("FAIL valid_extra got=%0d exp=0", ev_q.size()); end
    last_good = 8'h1C;
  endtask

  task automatic test_back_to_back;
    bit got; logic [8:0] ev;
    ev_q.delete();
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    get_ev(got, ev);
    n_tests++;
    if (!got || ev !== 9'h0F0) begin n_fail++; $display("FAIL b2b_first got=%h exp=0f0", ev); end
    get_ev(got, ev);
    n_tests++;
    if (!got || ev !== 9'h01C) begin n_fail++; $display("FAIL b2b_second got=%h exp=01c", ev); end
    n_tests++;
    if (byte_o !== 8'h1C) begin n_fail++; $display("FAIL b2b_byte got=%h exp=1c", byte_o); end
    last_good = 8'h1C;
  endtask

  task automatic test_bad_stop;
    bit got; logic [8:0] ev;
    ev_q.delete();
    send_frame(8'h2A, 1'b0, 1'b1);
    get_ev(got, ev);
    n_tests++;
    if (!got || ev !== 9'h100) begin n_fail++; $display("FAIL bad_stop_err got=%h exp=100", ev); end
    n_tests++;
    if (byte_o !== last_good) begin n_fail++; $display("FAIL bad_stop_hold got=%h exp=%h", byte_o, last_good); end
    send_frame(8'h2A, 1'b0, 1'b0);
    get_ev(got, ev);
    n_tests++;
    if (!got || ev !== 9'h02A) begin n_fail++; $display("FAIL bad_stop_next got=%h exp=02a", ev); end
    last_good = 8'h2A;
  endtask

  task automatic test_bad_parity;
    bit got; logic [8:0] ev, exp;
    ev_q.delete();
    exp = model(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b0);
    get_ev(got, ev);
    n_tests++;
    if (!got || ev !== exp) begin n_fail++; $display("FAIL bad_parity_event got=%h exp=%h", ev, exp); end
    if (!exp[8]) last_good = exp[7:0];
    n_tests++;
    if (byte_o !== last_good) begin n_fail++; $display("FAIL bad_parity_byte got=%h exp=%h", byte_o, last_good); end
    wait_clk(4);
    n_tests++;
    if (ev_q.size() != 0) begin n_fail++; $display("FAIL bad_parity_extra got=%0d exp=0", ev_q.size()); end
  endtask

  task automatic test_timeout;
    bit got; logic [8:0] ev;
    logic [7:0] b;
    int first, highs, bytes;
    b = 8'($urandom);
    ev_q.delete();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    // Last fall (D4) done by hand so the cycle distance to o_err can be measured.
    ps2_data = b[4];
    wait_clk(HALF / 2);
    ps2_clk = 1'b0;
    first = -1; highs = 0; bytes = 0;
    for (int c = 1; c <= int'(TMO) + 20; c++) begin
      wait_clk(1);
      if (c == HALF) ps2_clk = 1'b1;
      if (err) begin highs++; if (first < 0) first = c; end
      if (byte_en) bytes++;
    end
    // Fall is sampled at edge 1, detected by edge 3, then TMO idle cycles.
    n_tests++;
    if (first != int'(TMO) + 3) begin n_fail++; $display("FAIL timeout_latency got=%0d exp=%0d", first, TMO + 3); end
    n_tests++;
    if (highs != 1) begin n_fail++; $display("FAIL timeout_pulse got=%0d cycles exp=1", highs); end
    n_tests++;
    if (bytes != 0 || byte_o !== last_good) begin
      n_fail++; $display("FAIL timeout_hold got=%h/%0d exp=%h/0", byte_o, bytes, last_good);
    end
    ev_q.delete();
    send_frame(8'h45, 1'b0, 1'b0);
    get_ev(got, ev);
    n_tests++;
    if (!got || ev !== 9'h045 || byte_o !== 8'h45) begin
      n_fail++; $display("FAIL timeout_next got=%h byte=%h exp=045", ev, byte_o);
    end
    last_good = 8'h45;
  endtask

  task automatic test_reset_mid_frame;
    bit got; logic [8:0] ev;
    logic [7:0] b;
    b = 8'hF0;  // D4..D7, parity and stop are all ones
    ev_q.delete();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    sclr = 1'b1;
    wait_clk(2);
    n_tests++;
    if (byte_o !== 8'h00 || byte_en !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_outputs got=%h/%b/%b exp=00/0/0", byte_o, byte_en, err);
    end
    sclr = 1'b0;
    last_good = 8'h00;
    ev_q.delete();
    for (int i = 4; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b));
    send_bit(1'b1);
    wait_clk(8);
    n_tests++;
    if (ev_q.size() != 0) begin n_fail++; $display("FAIL mid_reset_tail got=%0d events exp=0", ev_q.size()); end
    ev_q.delete();
    send_frame(8'h16, 1'b0, 1'b0);
    get_ev(got, ev);
    n_tests++;
    if (!got || ev !== 9'h016 || byte_o !== 8'h16) begin
      n_fail++; $display("FAIL mid_reset_next got=%h byte=%h exp=016", ev, byte_o);
    end
    last_good = 8'h16;
  endtask

  task automatic test_random;
    bit got, bp, bs; logic [8:0] ev, exp;
    logic [7:0] b;
    ev_q.delete();
    for (int n = 0; n < 24; n++) begin
      b  = 8'($urandom);
      bp = ($urandom_range(0, 3) == 0);
      bs = ($urandom_range(0, 3) == 0);
      exp = model(b, bp, bs);
      send_frame(b, bp, bs);
      get_ev(got, ev);
      if (!exp[8]) last_good = exp[7:0];
      n_tests++;
      if (!got || ev !== exp) begin
        n_fail++; $display("FAIL random_event[%0d] got=%h exp=%h (b=%h bp=%0b bs=%0b)", n, ev, exp, b, bp, bs);
      end
      n_tests++;
      if (byte_o !== last_good) begin
        n_fail++; $display("FAIL random_byte[%0d] got=%h exp=%h", n, byte_o, last_good);
      end
    end
    wait_clk(4);
    n_tests++;
    if (ev_q.size() != 0) begin n_fail++; $display("FAIL random_extra got=%0d exp=0", ev_q.size()); end
    n_tests++;
    if (both_seen) begin n_fail++; $display("FAIL strobe_exclusive got=1 exp=0"); end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_back_to_back();
    test_bad_stop();
    test_bad_parity();
    test_timeout();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
# ps2_rx

- PS/2 device-to-host frame receiver: synchronises the raw `i_ps2_clk`/`i_ps2_data` pins into the system clock domain.
- Deserialises each 11-bit frame, checks its framing, and emits one received byte as a single-cycle strobe.
- Sits directly upstream of the make/break scancode filter, whose `i_byte`/`i_byte_en` inputs it drives.

## Interface
- `TIMEOUT_CYCLES`, 10000 — max `clk` cycles between consecutive PS/2 falling edges inside a frame before the frame is aborted (200 µs at 50 MHz).
- `clk` input 1 — system clock; all logic on the rising edge.
- `i_sclr` input 1 — reset, synchronous, active-high.
- `i_ps2_clk` input 1 — raw PS/2 clock pin, asynchronous, idles high.
- `i_ps2_data` input 1 — raw PS/2 data pin, asynchronous, idles high.
- `o_byte` output 8 — last correctly received byte.
- `o_byte_en` output 1 — one-cycle strobe, `o_byte` updated.
- `o_err` output 1 — one-cycle strobe, frame rejected.

## Operation
- **Synchronisers:** two flops per pin, reset value 1. A third flop on the synchronised clock is the edge-detect history, also reset to 1, so reset never creates a false edge.
- **Falling edge:** history = 1 and synchronised clock = 0. The synchronised data is sampled in the same cycle.
- **Frame format:** start (0), D0..D7 LSB first, odd parity, stop (1).
- **FSM states:**
  - IDLE
    - Edge with data = 0 → DATA, bit count = 0.
    - Edge with data = 1 → ignore, stay IDLE.
  - DATA
    - Each edge shifts data into bit[count] of the shift register.
    - After the 8th edge → PARITY.
  - PARITY
    - Edge latches the parity bit → STOP.
  - STOP
    - Edge with data = 1 and parity OK → load `o_byte`, pulse `o_byte_en`.
    - Edge with data = 0 → pulse `o_err`.
    - Either case → IDLE.
- **Parity OK:** XOR of D0..D7 and the parity bit = 1.
- **Timeout:**
  - Counter clears on every falling edge and in IDLE; it increments in all other states.
  - Reaching `TIMEOUT_CYCLES` → pulse `o_err`, go to IDLE, discard partial data.
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)` and it saturates; no wrap.
- **Simultaneous events:** a falling edge in the same cycle the timeout is reached takes priority; the counter clears and the edge is processed normally.
- `o_byte` holds its value across errors and timeouts.
- `o_byte_en` and `o_err` are never high in the same cycle.
- **Reset values:** `o_byte` = 0x00, `o_byte_en` = 0, `o_err` = 0, FSM = IDLE, counters = 0.
- **Reset mid-frame:** the partial frame is discarded. Reception restarts only at the next start bit seen after reset is released.

## Timing
- Let rising edge k be the first edge to sample `i_ps2_clk` low. The edge condition is true between edges k+1 and k+2. The FSM, `o_byte`, and the strobes update at edge k+2.
- `o_byte_en` is high for exactly the cycle after edge k+2 of the stop-bit fall, with `o_byte` already valid in that cycle.
- No backpressure. The downstream block must accept every strobe; the minimum spacing between strobes is one PS/2 frame.
- `i_ps2_data` must be stable for at least 3 `clk` cycles around each PS/2 clock fall. This holds for any `clk` ≥ 1 MHz.

## Configuration
- `PS2_PARITY_CHECK_EN` defined:
  - A bad parity bit in STOP → pulse `o_err`, no `o_byte_en`, `o_byte` unchanged.
- `PS2_PARITY_CHECK_EN` undefined:
  - The parity bit is clocked in and ignored.
  - Only the stop bit and the timeout can produce `o_err`.
  - Parity logic is removed.

## Test plan
- **Valid frame:** 0x1C, parity 0, stop 1 → `o_byte_en` one cycle, `o_byte` = 0x1C, `o_err` stays 0.
- **Back-to-back frames:** 0xF0 then 0x1C → two `o_byte_en` pulses; `o_byte` reads 0xF0 then 0x1C.
- **Bad parity** (macro defined): 0x1C with parity 1 → `o_err` one cycle, no `o_byte_en`, `o_byte` keeps its prior value. With the macro undefined → `o_byte_en`, `o_byte` = 0x1C.
- **Bad stop:** stop bit 0 on frame 0x2A → `o_err` one cycle, no `o_byte_en`. Next valid frame 0x2A → accepted.
- **Timeout:** PS/2 clock stops after D4 → `o_err` exactly `TIMEOUT_CYCLES` cycles after the last fall, FSM = IDLE. The following full frame 0x45 → `o_byte` = 0x45.
- **Reset during D3:** outputs 0 after the reset edge. The remainder of the aborted frame produces no strobe, since its data-bit falls are ignored in IDLE unless data = 0. The next clean frame 0x16 → `o_byte` = 0x16.
